rr_arbiter_8: RTL
=================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters, using the same one-hot-in / 3-bit-index-out convention as the 8-to-3 encoder.
- Sits in front of the shared datapath. It registers a one-hot grant, the encoded grant index and a valid flag.
- A grant is held until the owner drops its request, the hold limit expires, or the arbiter is disabled.
- Fairness comes from a rotating priority pointer.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester may hold the grant (legal range 1..255).
- CNT_W, 8: width of the internal hold counter. It must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low. Sampled only at the rising edge of clk.
- En  input  1  arbiter enable.
- Req  input  8  request vector, one bit per requester. Requester i drives bit i.
- Gnt  output  8  registered one-hot grant. All zeros when no grant.
- Gnt_id  output  3  registered encoded index of the granted requester.
- Gnt_valid  output  1  high while any grant is active.
- Timeout  output  1  one-cycle pulse on the edge where a grant is revoked by the hold limit.

Behaviour:
- Reset (rst_n=0 at posedge, regardless of state or En):
  - Gnt=0, Gnt_id=0, Gnt_valid=0, Timeout=0.
  - ptr=0, hold_cnt=0, state=IDLE.
  - Reset mid-grant drops the grant on that same edge.
- Winner selection:
  - The first set bit of Req found by searching ascending and circularly from ptr (ptr, ptr+1, ..., 7, 0, ..., ptr-1).
  - The index wraps modulo 8.
  - Pure function of Req and ptr.
- State IDLE:
  - If En=1 and Req!=0 at posedge: register winner into Gnt/Gnt_id, set Gnt_valid=1, set hold_cnt=1, go to GRANT.
  - Otherwise all outputs stay 0.
  - Latency from request to grant is one cycle.
- State GRANT, release conditions evaluated at each posedge:
  - (a) En=0: Gnt=0, Gnt_valid=0, ptr=Gnt_id+1 mod 8, go to IDLE. Gnt_id keeps its last value.
  - (b) Req[Gnt_id]=0: release.
  - (c) hold_cnt==MAX_HOLD: release, with Timeout=1 for exactly that cycle.
  - Priority: (a) over (b) over (c).
- Release under (b) or (c):
  - ptr=Gnt_id+1 mod 8.
  - The winner is re-evaluated on the same edge using the new ptr and the current Req. This gives a zero-bubble handoff.
  - If a winner exists: load it and set hold_cnt=1. The current holder can re-win only if it is the sole requester.
  - If no winner exists: go to IDLE with Gnt=0 and Gnt_valid=0.
- No release condition met: hold_cnt increments. Changes to non-owner Req bits never pre-empt the owner.
- Invariants:
  - The grant duration is at most MAX_HOLD cycles.
  - Gnt is always 0 or one-hot.
  - Gnt = 1<<Gnt_id whenever Gnt_valid=1.
  - Timeout is never high in IDLE.
- MAX_HOLD=1: every grant lasts one cycle. Contending requesters alternate every cycle and Timeout pulses each cycle.

Test Plan:
- Basic grant and handoff:
  - Stimulus: after reset, En=1, Req=8'b00010010.
  - Response: next edge Gnt=8'b00000010, Gnt_id=1, Gnt_valid=1.
  - Then drop Req[1]: next edge Gnt=8'b00010000, Gnt_id=4, with no bubble cycle.
- Hold limit:
  - Stimulus: MAX_HOLD=4, Req=8'b10000001 held constant.
  - Response: Gnt_id=0 for 4 cycles, Timeout=1 on the handoff edge, then Gnt_id=7 for 4 cycles (Timeout pulse), then Gnt_id=0.
  - This also checks wrap of ptr from 7 to 0.
- Sole requester timeout:
  - Stimulus: Req=8'b00001000 constant.
  - Response: Gnt_id=3 continuously. Timeout pulses every 4th cycle. Gnt_valid never drops.
- Disable:
  - Stimulus: En=0 during a grant of id 2, with Req=8'b00101100.
  - Response: next edge Gnt=0, Gnt_valid=0, Timeout=0.
  - Then En=1: the grant goes to id 3 (ptr=3).
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge while Gnt_id=5.
  - Response: all outputs 0 on that edge.
  - Then with Req=8'b11111111 and En=1: the first grant is id 0.
- Idle and no request:
  - Stimulus: En=1, Req=0 for 5 cycles.
  - Response: Gnt=0, Gnt_valid=0 and Timeout=0 throughout.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter for 8 requesters with hold limit and zero-bubble handoff
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       En,
  input  logic [7:0] Req,
  output logic [7:0] Gnt,
  output logic [2:0] Gnt_id,
  output logic       Gnt_valid,
  output logic       Timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t             r_state, w_state_nx;
  logic [2:0]         r_ptr, w_ptr_nx, r_id, w_id_nx, w_sel, w_win;
  logic [CNT_W-1:0]   r_hold, w_hold_nx;
  logic [7:0]         r_gnt, w_gnt_nx;
  logic               r_valid, w_valid_nx, r_to, w_to_nx;
  logic               w_found, w_own, w_lim, w_rel;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_id    <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_hold  <= w_hold_nx;
      r_id    <= w_id_nx;
      r_gnt   <= w_gnt_nx;
      r_valid <= w_valid_nx;
      r_to    <= w_to_nx;
    end
  end
  // a releasing holder searches from its successor, so it only re-wins when alone
  assign w_sel = (r_state == GRANT) ? r_id + 3'd1 : r_ptr;
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 7; k >= 0; k--) begin
      if (Req[w_sel + 3'(k)]) begin
        w_found = 1'b1;
        w_win   = w_sel + 3'(k);
      end
    end
  end
  assign w_own = Req[r_id];
  assign w_lim = r_hold == CNT_W'(MAX_HOLD);
  assign w_rel = !w_own || w_lim;
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_hold_nx  = r_hold;
    w_id_nx    = r_id;
    w_to_nx    = 1'b0;
    if (r_state == IDLE) begin
      if (En && w_found) begin
        w_state_nx = GRANT;
        w_id_nx    = w_win;
        w_hold_nx  = CNT_W'(1);
      end
    end else if (!En) begin
      w_state_nx = IDLE;
      w_ptr_nx   = r_id + 3'd1;
      w_hold_nx  = '0;
    end else if (w_rel) begin
      w_ptr_nx   = r_id + 3'd1;
      w_to_nx    = w_own;
      w_state_nx = w_found ? GRANT : IDLE;
      w_id_nx    = w_found ? w_win : r_id;
      w_hold_nx  = w_found ? CNT_W'(1) : '0;
    end else begin
      w_hold_nx  = r_hold + CNT_W'(1);
    end
  end
  always_comb begin
    w_valid_nx = w_state_nx == GRANT;
    w_gnt_nx   = w_valid_nx ? 8'd1 << w_id_nx : 8'd0;
  end
  assign Gnt       = r_gnt;
  assign Gnt_id    = r_id;
  assign Gnt_valid = r_valid;
  assign Timeout   = r_to;
endmodule
